// File: rtl/burst_memory_responder.sv
// burst_memory_responder
// Memory-side responder for the 4-beat x 64-bit burst protocol. A read or
// write request is accepted in IDLE, held for LATENCY cycles, then one
// 256-bit line moves as four beats qualified by resp_o (beat 0 = LSBs).
// The line store is split into four 64-bit-wide arrays, one per beat slice,
// so each beat writes a single narrow RAM and reads use one registered line.
// Optional feature macro: BURST_MEM_GAP_EN inserts a one-cycle gap after
// beats 0..2 so initiators see non-consecutive resp_o strobes.

module burst_memory_responder #(
  parameter int DEPTH_LINES = 16,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
);

  localparam int         IDX_W    = $clog2(DEPTH_LINES);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

`ifdef BURST_MEM_GAP_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_BEAT = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_BEAT = 3'd2,
    ST_DONE = 3'd3
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [3:0]         lat_q, lat_d;
  logic [1:0]         beat_q, beat_d;
  logic               rd_q, rd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        line_q [4];
  logic               accept;
  logic [IDX_W-1:0]   addr_idx;
  logic               unused_addr_bits;

  assign addr_idx         = address_i[5 +: IDX_W];
  // Offset bits and aliased upper bits carry no meaning for the line index.
  assign unused_addr_bits = ^{address_i[31:5+IDX_W], address_i[4:0]};

  // Next-state logic: request arbitration, latency countdown and beat sequencing.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    rd_d    = rd_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (read_i || write_i) begin
          accept  = 1'b1;
          rd_d    = read_i;           // read wins when both are raised
          idx_d   = addr_idx;
          lat_d   = LAT_INIT;
          beat_d  = 2'd0;
          state_d = (LATENCY > 0) ? ST_WAIT : ST_BEAT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) begin
          state_d = ST_BEAT;
        end
      end
      ST_BEAT: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
`ifdef BURST_MEM_GAP_EN
          state_d = ST_GAP;
`else
          state_d = ST_BEAT;
`endif
        end
      end
`ifdef BURST_MEM_GAP_EN
      ST_GAP: begin
        state_d = ST_BEAT;
      end
`endif
      ST_DONE: begin
        // Initiator is dropping its request this cycle; ignore it.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset returns to IDLE at any point, even mid-burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      lat_q   <= 4'd0;
      beat_q  <= 2'd0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      rd_q    <= rd_d;
      idx_q   <= idx_d;
    end
  end

  // One narrow RAM per beat slice; written during its own beat, read into
  // the line register at request acceptance.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    logic [63:0] mem [DEPTH_LINES];
    logic        slice_we;

    assign slice_we = (state_q == ST_BEAT) && !rd_q && (beat_q == 2'(gi));

    // Write port: beat data lands at the edge that ends the beat.
    always_ff @(posedge clk) begin
      if (slice_we) begin
        mem[idx_q] <= burst_i;
      end
    end

    // Registered read port: snapshot of the slice taken when a request is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        line_q[gi] <= 64'h0;
      end else if (accept) begin
        line_q[gi] <= mem[addr_idx];
      end
    end
  end

  // Outputs are decoded purely from registered state.
  assign resp_o  = (state_q == ST_BEAT);
  assign burst_o = (resp_o && rd_q) ? line_q[beat_q] : 64'h0;

endmodule

// File: doc/burst_memory_responder.md
# burst_memory_responder

Memory-side responder for the 4-beat, 64-bit burst protocol used between the cacheline adaptor and main memory. Accepts a read or write request with a 32-bit line address, waits a programmable latency, then transfers one 256-bit line as four 64-bit beats, each qualified by `resp_o`. Holds a small synthesizable line store and serves as both the memory model for cache-subsystem benches and the FPGA stand-in for external memory.

## Interface
- `DEPTH_LINES`, 16: number of 256-bit lines stored; power of two, ≥2.
- `LATENCY`, 2: idle cycles between request acceptance and first beat; range 0–15.

- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `address_i`  in  32  line address; bits [4:0] ignored, index = `address_i[5 +: $clog2(DEPTH_LINES)]`, upper bits ignored (aliasing).
- `read_i`  in  1  read request; initiator holds it high until the 4th beat.
- `write_i`  in  1  write request; initiator holds it high until the 4th beat.
- `burst_i`  in  64  write beat data; sampled on cycles with `resp_o`=1 during writes.
- `burst_o`  out  64  read beat data; valid when `resp_o`=1 during reads, else 64'h0.
- `resp_o`  out  1  beat strobe; one beat transferred per high cycle.

## Operation
- States: IDLE, WAIT, BEAT, GAP (only with macro), DONE.
- IDLE: if `read_i` → accept read; else if `write_i` → accept write (read wins when both high). On accept: latch index and direction, load latency counter with `LATENCY`, beat counter = 0; next = WAIT if `LATENCY`>0, else BEAT.
- WAIT: counter decrements each cycle; when it reaches 1 → BEAT.
- BEAT: `resp_o`=1. Beat n carries line bits [64n+63:64n], n=0..3 (beat 0 = LSBs).
  - Read: `burst_o` = stored line slice n, from a 256-bit line register loaded from the array at accept.
  - Write: `burst_i` written directly to array slice n of the latched index at the clock edge ending the beat.
  - Beat counter increments; after beat 3 → DONE.
- DONE: one cycle, `resp_o`=0, requests ignored (initiator is dropping its request this cycle); → IDLE.
- Latched address/direction are fixed for the transaction; `address_i` changes after accept are ignored.
- Request deasserted mid-transaction (protocol violation): all four beats are still issued; writes use whatever `burst_i` holds.
- Reset (any time, including mid-burst): state IDLE, counters 0, line register 0, `resp_o`=0, `burst_o`=0. Array is not reset; contents survive reset, undefined after power-up.
- Read-after-write to the same index returns the new line; a partially completed write (reset mid-burst) leaves already-written slices updated.

## Timing
- Accept in cycle T (IDLE, request high) with `LATENCY`=L.
- Without macro: `resp_o` high in cycles T+1+L … T+4+L back-to-back; DONE at T+5+L; IDLE (can accept) at T+6+L.
- L=0: first beat at T+1.
- `resp_o` and `burst_o` are decoded from registered state only; no combinational path from any input to any output.
- Minimum request-to-request spacing: 6+L cycles (back-to-back mode).

## Configuration
- `BURST_MEM_GAP_EN`: when defined, a one-cycle GAP state (`resp_o`=0, `burst_o`=0) is inserted after each of beats 0–2; beats at T+1+L, T+3+L, T+5+L, T+7+L, DONE at T+8+L. Exercises initiator tolerance of non-consecutive `resp`. When undefined, GAP state does not exist and beats are back-to-back.

## Test plan
- Write address 32'h0000_0040, beats 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444… (L=2) → `resp_o` high cycles T+3..T+6; later read of 32'h0000_0040 returns the same four beats in order.
- Read and write asserted together at 32'h0000_0080 → treated as read, array unchanged.
- Aliasing: write 32'h0000_0000 then read 32'h0000_0200 (DEPTH_LINES=16) → identical data.
- L=0 read → first `resp_o` at T+1; DONE at T+5; new request accepted at T+6, not T+5.
- Reset asserted during beat 2 of a write → `resp_o`=0 immediately, state IDLE; subsequent read shows beats 0–1 new, beats 2–3 old.
- `BURST_MEM_GAP_EN` defined, L=1 → `resp_o` pattern 1,0,1,0,1,0,1 starting T+2; data matches back-to-back build.
